// File: rtl/ap_ctrl_sequencer.sv
// Initiator for the HLS ap_ctrl_chain handshake: issues a programmed number of kernel
// invocations with up to MAX_OUT in flight and records per-invocation latency.
// Optional continue back-pressure injection: define AP_CTRL_SEQ_STALL_INJECT_EN.
module ap_ctrl_sequencer #(
    parameter int CNT_W   = 16,
    parameter int LAT_W   = 32,
    parameter int MAX_OUT = 4
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             cfg_start,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic             cfg_abort,
`ifdef AP_CTRL_SEQ_STALL_INJECT_EN
    input  logic             stall_en,
`endif
    output logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    output logic             ap_continue,
    output logic             busy,
    output logic             run_done,
    output logic [CNT_W-1:0] issued,
    output logic [CNT_W-1:0] completed,
    output logic [LAT_W-1:0] last_lat,
    output logic [LAT_W-1:0] max_lat,
    output logic             err,
    output logic [1:0]       dbg_state
);

    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(MAX_OUT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] target, target_nxt;
    logic [CNT_W-1:0] issued_nxt, completed_nxt, outstanding, outst_nxt;
    logic [LAT_W-1:0] timer, lat;
    logic [LAT_W-1:0] ts_mem [MAX_OUT];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             abort_pend, zero_done;
    logic             accept, done_ok, complete, spurious, bypass, push, pop;
    logic             start_run, stop_now, start_nxt;

    function automatic logic [PTR_W-1:0] ptr_adv(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

`ifdef AP_CTRL_SEQ_STALL_INJECT_EN
    logic [15:0] lfsr;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) lfsr <= 16'hACE1;
        else           lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign ap_continue = busy & (~stall_en | (lfsr[1:0] != 2'b00));
`else
    assign ap_continue = busy;
`endif

    // Handshake: an invocation is accepted on a cycle with ap_start & ap_ready and
    // completes on a cycle with ap_done & ap_continue; ap_start never drops unaccepted.
    assign accept        = ap_start & ap_ready;
    assign outstanding   = issued - completed;
    assign done_ok       = ap_done & ap_continue;
    assign complete      = done_ok & ((outstanding != '0) | accept);
    assign spurious      = done_ok & (outstanding == '0) & ~accept;
    assign bypass        = complete & (outstanding == '0);
    assign push          = accept & ~bypass;
    assign pop           = complete & ~bypass;
    assign lat           = bypass ? '0 : (timer - ts_mem[rd_ptr]);
    assign start_run     = (state == S_IDLE) & cfg_start & (cfg_count != '0);
    assign stop_now      = (abort_pend | cfg_abort) & ~(ap_start & ~ap_ready);
    assign issued_nxt    = start_run ? '0 : issued + CNT_W'(accept);
    assign completed_nxt = start_run ? '0 : completed + CNT_W'(complete);
    assign outst_nxt     = issued_nxt - completed_nxt;
    assign run_done      = zero_done | ((state == S_DRAIN) & (completed == target));

    always_comb begin
        state_nxt  = state;
        target_nxt = target;
        case (state)
            S_IDLE: if (start_run) begin
                state_nxt  = S_RUN;
                target_nxt = cfg_count;
            end
            S_RUN: if (issued == target) begin
                state_nxt = S_DRAIN;
            end else if (stop_now) begin
                // An abort shrinks the run to whatever has been accepted so far.
                state_nxt  = S_DRAIN;
                target_nxt = issued_nxt;
            end
            S_DRAIN: if (completed == target) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Evaluated on next-cycle counters so a continuous issue yields back-to-back accepts.
    assign start_nxt = (ap_start & ~ap_ready) |
                       ((state_nxt == S_RUN) & (issued_nxt < target_nxt) & (outst_nxt < MAX_OUT_C));

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state      <= S_IDLE;
            target     <= '0;
            issued     <= '0;
            completed  <= '0;
            ap_start   <= 1'b0;
            timer      <= '0;
            zero_done  <= 1'b0;
            abort_pend <= 1'b0;
            last_lat   <= '0;
            max_lat    <= '0;
            err        <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            state      <= state_nxt;
            target     <= target_nxt;
            issued     <= issued_nxt;
            completed  <= completed_nxt;
            ap_start   <= start_nxt;
            timer      <= timer + 1'b1;
            zero_done  <= (state == S_IDLE) & cfg_start & (cfg_count == '0);
            abort_pend <= (state == S_RUN) & (state_nxt == S_RUN) & (abort_pend | cfg_abort);
            if (start_run) begin
                last_lat <= '0;
                max_lat  <= '0;
                err      <= 1'b0;
            end else begin
                if (complete) begin
                    last_lat <= lat;
                    if (lat > max_lat) max_lat <= lat;
                end
                if (spurious) err <= 1'b1;
            end
            if (push) wr_ptr <= ptr_adv(wr_ptr);
            if (pop)  rd_ptr <= ptr_adv(rd_ptr);
        end
    end

    always_ff @(posedge ap_clk) begin
        if (push) ts_mem[wr_ptr] <= timer;
    end

endmodule

// File: tb/tb_ap_ctrl_sequencer.sv
// Directed bench for ap_ctrl_sequencer: a MAX_OUT=4 instance driven by a fixed-latency
// kernel model, plus a MAX_OUT=1 instance driven by hand for the serial case.
module tb_ap_ctrl_sequencer;
  localparam int CNT_W = 16;
  localparam int LAT_W = 32;

  // clock / reset
  logic ap_clk = 1'b0;
  logic ap_rst_n;
  always #5 ap_clk = ~ap_clk;

  // main instance (MAX_OUT = 4)
  logic             cfg_start = 1'b0, cfg_abort = 1'b0;
  logic [CNT_W-1:0] cfg_count = '0;
  logic             ap_start, ap_ready, ap_done, ap_continue, busy, run_done, err;
  logic [CNT_W-1:0] issued, completed;
  logic [LAT_W-1:0] last_lat, max_lat;
  logic [1:0]       dbg_state;
  logic             model_done = 1'b0;
  logic             man_done = 1'b0;
  assign ap_done = model_done | man_done;

  // serial instance (MAX_OUT = 1)
  logic             b_start = 1'b0, b_abort = 1'b0, b_ready = 1'b0, b_done = 1'b0;
  logic [CNT_W-1:0] b_count = '0;
  logic             b_ap_start, b_cont, b_busy, b_run_done, b_err;
  logic [CNT_W-1:0] b_issued, b_completed;
  logic [LAT_W-1:0] b_last, b_max;
  logic [1:0]       b_state;

  int checks = 0;
  int errors = 0;

  // kernel model + scoreboard
  int cyc = 0;
  int k_lat = 20;
  int done_q[$];
  logic [LAT_W-1:0] exp_q[$];

  ap_ctrl_sequencer #(.CNT_W(CNT_W), .LAT_W(LAT_W), .MAX_OUT(4)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .cfg_start(cfg_start), .cfg_count(cfg_count),
    .cfg_abort(cfg_abort),
`ifdef AP_CTRL_SEQ_STALL_INJECT_EN
    .stall_en(1'b0),
`endif
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .busy(busy), .run_done(run_done), .issued(issued), .completed(completed),
    .last_lat(last_lat), .max_lat(max_lat), .err(err), .dbg_state(dbg_state)
  );

  ap_ctrl_sequencer #(.CNT_W(CNT_W), .LAT_W(LAT_W), .MAX_OUT(1)) dut1 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .cfg_start(b_start), .cfg_count(b_count),
    .cfg_abort(b_abort),
`ifdef AP_CTRL_SEQ_STALL_INJECT_EN
    .stall_en(1'b0),
`endif
    .ap_start(b_ap_start), .ap_ready(b_ready), .ap_done(b_done), .ap_continue(b_cont),
    .busy(b_busy), .run_done(b_run_done), .issued(b_issued), .completed(b_completed),
    .last_lat(b_last), .max_lat(b_max), .err(b_err), .dbg_state(b_state)
  );

  // Kernel: every accept on the main instance finishes k_lat edges later.
  always @(posedge ap_clk) begin
    if (model_done) done_q.delete(0);
    if (ap_start && ap_ready) done_q.push_back(cyc + k_lat);
    cyc++;
  end

  always @(negedge ap_clk) model_done = (done_q.size() > 0) && (done_q[0] == cyc);

  // driver tasks
  task automatic tick();
    @(negedge ap_clk);
  endtask

  task automatic start_main(input logic [CNT_W-1:0] n);
    cfg_count = n;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic test_reset();
    int c;
    ap_rst_n = 1'b1;
    #1 ap_rst_n = 1'b0;
    tick(); tick();
    checks++; if (ap_start !== 1'b0 || busy !== 1'b0 || run_done !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL rst_ctrl: start=%b busy=%b run_done=%b err=%b want 0000", ap_start, busy, run_done, err); end
    checks++; if (issued !== '0 || completed !== '0 || last_lat !== '0 || max_lat !== '0) begin
      errors++; $display("FAIL rst_counts: iss=%0d cmp=%0d last=%0d max=%0d want 0", issued, completed, last_lat, max_lat); end
    checks++; if (b_ap_start !== 1'b0 || b_busy !== 1'b0 || b_issued !== '0) begin
      errors++; $display("FAIL rst_serial: start=%b busy=%b iss=%0d want 0", b_ap_start, b_busy, b_issued); end
    ap_rst_n = 1'b1;
    tick();
    k_lat = 20;
    ap_ready = 1'b1;
    start_main(16'd4);
    c = 0;
    while (issued != 16'd2 && c < 10) begin tick(); c++; end
    checks++; if (issued !== 16'd2 || completed !== 16'd0 || ap_start !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL rst_prerun: iss=%0d cmp=%0d start=%b busy=%b want 2 0 1 1", issued, completed, ap_start, busy); end
    #2 ap_rst_n = 1'b0;
    #1;
    checks++; if (ap_start !== 1'b0 || busy !== 1'b0 || ap_continue !== 1'b0 || run_done !== 1'b0) begin
      errors++; $display("FAIL rst_midrun_ctrl: start=%b busy=%b cont=%b run_done=%b want 0", ap_start, busy, ap_continue, run_done); end
    checks++; if (issued !== '0 || completed !== '0 || err !== 1'b0) begin
      errors++; $display("FAIL rst_midrun_counts: iss=%0d cmp=%0d err=%b want 0", issued, completed, err); end
    done_q.delete();
    ap_ready = 1'b0;
    tick(); tick();
    ap_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_window();
    int rd = 0, stall_bad = 0, peak = 0;
    logic [CNT_W-1:0] prev_c = '0;
    logic [LAT_W-1:0] exp;
    bit fin = 0;
    for (int i = 0; i < 8; i++) exp_q.push_back(32'd20);
    k_lat = 20;
    ap_ready = 1'b1;
    start_main(16'd8);
    for (int c = 0; c < 120 && !fin; c++) begin
      tick();
      if (c == 9) begin
        checks++; if (issued !== 16'd4 || ap_start !== 1'b0) begin
          errors++; $display("FAIL win_stall: iss=%0d start=%b want 4 0", issued, ap_start); end
      end
      if (int'(issued - completed) > peak) peak = int'(issued - completed);
      if (ap_start && (issued - completed) == 16'd4) stall_bad++;
      if (completed != prev_c) begin
        prev_c = completed;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        checks++; if (last_lat !== exp) begin
          errors++; $display("FAIL win_lat: cmp=%0d last_lat=%0d want %0d", completed, last_lat, exp); end
      end
      if (run_done) rd++;
      if (!busy) fin = 1;
    end
    checks++; if (!fin || issued !== 16'd8 || completed !== 16'd8) begin
      errors++; $display("FAIL win_counts: fin=%0d iss=%0d cmp=%0d want 1 8 8", fin, issued, completed); end
    checks++; if (max_lat !== 32'd20 || err !== 1'b0 || rd != 1) begin
      errors++; $display("FAIL win_stats: max=%0d err=%b run_done_pulses=%0d want 20 0 1", max_lat, err, rd); end
    checks++; if (peak != 4 || stall_bad != 0 || exp_q.size() != 0) begin
      errors++; $display("FAIL win_outstanding: peak=%0d start_at_4=%0d left=%0d want 4 0 0", peak, stall_bad, exp_q.size()); end
  endtask

  task automatic test_serial();
    int pend = 0, rd = 0, bad = 0;
    logic [CNT_W-1:0] prev = '0;
    bit fin = 0;
    b_ready = 1'b1;
    b_count = 16'd3;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int c = 0; c < 80 && !fin; c++) begin
      b_done = 1'b0;
      if (pend > 0) begin pend--; if (pend == 0) b_done = 1'b1; end
      if (b_issued != prev) begin pend = 4; prev = b_issued; end
      if (b_run_done) rd++;
      if (b_ap_start && (b_issued != b_completed)) bad++;
      if (!b_busy) fin = 1; else tick();
    end
    b_done = 1'b0;
    checks++; if (!fin || b_issued !== 16'd3 || b_completed !== 16'd3) begin
      errors++; $display("FAIL ser_counts: fin=%0d iss=%0d cmp=%0d want 1 3 3", fin, b_issued, b_completed); end
    checks++; if (b_last !== 32'd5 || b_max !== 32'd5) begin
      errors++; $display("FAIL ser_lat: last=%0d max=%0d want 5 5", b_last, b_max); end
    checks++; if (rd != 1 || bad != 0 || b_err !== 1'b0) begin
      errors++; $display("FAIL ser_ctrl: run_done_pulses=%0d start_with_outstanding=%0d err=%b want 1 0 0", rd, bad, b_err); end
  endtask

  task automatic test_zero();
    start_main(16'd0);
    checks++; if (run_done !== 1'b1 || busy !== 1'b0 || ap_start !== 1'b0) begin
      errors++; $display("FAIL zero_pulse: run_done=%b busy=%b start=%b want 1 0 0", run_done, busy, ap_start); end
    tick();
    checks++; if (run_done !== 1'b0 || ap_start !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_after: run_done=%b start=%b busy=%b want 0 0 0", run_done, ap_start, busy); end
  endtask

  task automatic test_abort();
    int c = 0, rd = 0;
    k_lat = 2;
    ap_ready = 1'b1;
    start_main(16'd10);
    while (issued != 16'd4 && c < 20) begin tick(); c++; end
    ap_ready = 1'b0;
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    tick(); tick();
    checks++; if (ap_start !== 1'b1 || issued !== 16'd4 || busy !== 1'b1) begin
      errors++; $display("FAIL abort_hold: start=%b iss=%0d busy=%b want 1 4 1", ap_start, issued, busy); end
    ap_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (run_done) rd++;
      if (!busy) break;
    end
    checks++; if (issued !== 16'd5 || completed !== 16'd5) begin
      errors++; $display("FAIL abort_counts: iss=%0d cmp=%0d want 5 5", issued, completed); end
    checks++; if (rd != 1 || busy !== 1'b0 || ap_start !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL abort_end: run_done_pulses=%0d busy=%b start=%b err=%b want 1 0 0 0", rd, busy, ap_start, err); end
  endtask

  task automatic test_spurious();
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    checks++; if (err !== 1'b0 || ap_continue !== 1'b0) begin
      errors++; $display("FAIL spur_idle: err=%b cont=%b want 0 0", err, ap_continue); end
    k_lat = 2;
    ap_ready = 1'b0;
    start_main(16'd2);
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    checks++; if (err !== 1'b1 || completed !== 16'd0 || issued !== 16'd0) begin
      errors++; $display("FAIL spur_run: err=%b cmp=%0d iss=%0d want 1 0 0", err, completed, issued); end
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    ap_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (!busy) break;
    end
    checks++; if (busy !== 1'b0 || issued !== 16'd1 || completed !== 16'd1 || err !== 1'b1 || last_lat !== 32'd2) begin
      errors++; $display("FAIL spur_end: busy=%b iss=%0d cmp=%0d err=%b last=%0d want 0 1 1 1 2",
                         busy, issued, completed, err, last_lat); end
  endtask

  initial begin
    test_reset();
    test_window();
    test_serial();
    test_zero();
    test_abort();
    test_spurious();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/ap_ctrl_sequencer.md
Name: ap_ctrl_sequencer

Overview:
- Synthesizable initiator for the HLS block-level control protocol (ap_start/ap_ready/ap_done/ap_continue, ap_ctrl_chain semantics).
- Issues a programmed number of back-to-back invocations of one HLS kernel, allowing up to MAX_OUT invocations in flight.
- Records per-invocation latency, so on-hardware runs yield the same start/ready/done statistics that simulation dumps produce.
- Sits between a CSR/test harness and the kernel top (e.g. the tiled systolic mmult).

Parameters:
- CNT_W, 16: width of invocation count and issued/completed counters.
- LAT_W, 32: width of free-running timer and latency results.
- MAX_OUT, 4: max outstanding invocations (accepted, not yet done). Power of two, 1..16.

Ports:
- ap_clk  in  1  clock.
- ap_rst_n  in  1  asynchronous active-low reset.
- cfg_start  in  1  one-cycle pulse; begins a run when idle.
- cfg_count  in  CNT_W  number of invocations, sampled with cfg_start.
- cfg_abort  in  1  one-cycle pulse; stop issuing, drain outstanding.
- ap_start  out  1  to kernel.
- ap_ready  in  1  from kernel.
- ap_done  in  1  from kernel.
- ap_continue  out  1  to kernel.
- busy  out  1  run in progress.
- run_done  out  1  one-cycle pulse at run completion.
- issued  out  CNT_W  invocations accepted (ap_start & ap_ready).
- completed  out  CNT_W  invocations finished (ap_done & ap_continue).
- last_lat  out  LAT_W  latency of most recent completion.
- max_lat  out  LAT_W  maximum latency this run.
- err  out  1  sticky: ap_done & ap_continue with zero outstanding.

Behaviour:
- Reset (async, ap_rst_n=0): every output 0, FSM IDLE, timestamp FIFO empty, timer 0.
- Timer: free-running LAT_W counter that wraps. Latency = timer_at_complete - timestamp_at_accept, modulo 2^LAT_W. Accept and complete in the same cycle gives 0 (FIFO bypass).
- FSM states IDLE, RUN, DRAIN.
- IDLE, cfg_start=1, cfg_count!=0:
  - latch target=cfg_count; clear issued, completed, last_lat, max_lat, err.
  - go to RUN; busy=1 from the next cycle.
- IDLE, cfg_start=1, cfg_count=0: run_done=1 on the next cycle, stay IDLE, ap_start never asserted.
- cfg_start while busy: ignored.
- RUN, issue:
  - ap_start is a register. It is set when issued < target and outstanding < MAX_OUT.
  - Once set, it holds until sampled with ap_ready=1 (accept). It must never drop before ready.
  - On accept: issued++, timer value pushed to the FIFO (depth MAX_OUT). ap_start re-evaluates the next cycle, so a continuous issue gives back-to-back accepts.
- RUN/DRAIN, completion:
  - ap_continue = busy.
  - Completion = ap_done & ap_continue & outstanding>0 (outstanding = issued - completed, counting the same-cycle accept).
  - On completion: pop FIFO, completed++, update last_lat, max_lat = max(max_lat, lat).
  - Done with outstanding==0 and no same-cycle accept: err=1, counters unchanged.
- RUN -> DRAIN when issued reaches target (the cycle after the final accept).
- cfg_abort in RUN:
  - if ap_start is 1, it keeps waiting for ap_ready; that accept still counts.
  - then target := issued and the FSM goes to DRAIN.
  - cfg_abort in IDLE/DRAIN: ignored.
- DRAIN -> IDLE when completed==target. That cycle run_done=1; busy=0 the cycle after.
- FIFO full while accepting cannot occur (issue gating). Simultaneous push+pop keeps occupancy constant.
- Counters do not wrap; target ≤ 2^CNT_W-1.

Optional Feature:
- Macro AP_CTRL_SEQ_STALL_INJECT_EN.
- Defined:
  - adds a 16-bit LFSR (seed 16'hACE1, taps 16,14,13,11), advanced every cycle.
  - ap_continue = busy & (lfsr[1:0]!=2'b00), giving ~25% continue back-pressure. Completion rules use this gated ap_continue.
  - adds input stall_en (1 bit); stall_en=0 forces ungated behaviour.
- Undefined: no LFSR, no stall_en port, ap_continue = busy.

Test Plan:
- Reset mid-run (ap_rst_n low during RUN with 2 outstanding) -> all outputs 0 immediately, busy=0; next cfg_start behaves as fresh.
- cfg_count=3, kernel ready same cycle as start, done 5 cycles after accept, MAX_OUT=1 -> issued/completed reach 3, last_lat=max_lat=5, one run_done pulse, ap_start never high while 1 outstanding.
- cfg_count=8, MAX_OUT=4, done latency 20 -> ap_start stalls after 4 accepts until first done; completed=8, err=0.
- cfg_count=0 -> run_done pulse the next cycle, ap_start stays 0.
- cfg_count=10, cfg_abort after 4th accept with ap_start pending, ready 3 cycles later -> issued=5, completed=5, run_done, busy=0.
- Spurious ap_done in IDLE -> err stays 0 (ap_continue=0). Spurious ap_done during RUN with 0 outstanding -> err=1, completed unchanged.
